// File: rtl/full_adder_unit_if.sv
// full_adder_unit_if: operand/result bundle for full_adder_unit.
// The overflow signal exists only when FULL_ADDER_UNIT_OVERFLOW_EN is defined.
// The master side drives operands and clear; the slave side returns results.
interface full_adder_unit_if #(
  parameter int WIDTH = 1
) ();
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  logic             overflow;

  modport master (
    output clr, in_valid, a, b, cin,
    input  out_valid, sum, carry, overflow
  );

  modport slave (
    input  clr, in_valid, a, b, cin,
    output out_valid, sum, carry, overflow
  );
`else
  modport master (
    output clr, in_valid, a, b, cin,
    input  out_valid, sum, carry
  );

  modport slave (
    input  clr, in_valid, a, b, cin,
    output out_valid, sum, carry
  );
`endif
endinterface

// File: rtl/full_adder_unit.sv
// full_adder_unit: registered WIDTH-bit ripple-carry adder.
// The WIDTH+1 bit result {carry, sum} = a + b + cin appears one clock after
// a valid input. Define FULL_ADDER_UNIT_OVERFLOW_EN to add a registered
// two's-complement overflow flag (c_WIDTH ^ c_WIDTH-1).
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  full_adder_unit_if.slave        bus
);

  // Carry chain: chain[0] is cin, chain[WIDTH] is the carry-out.
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             out_valid_reg;

  assign chain[0] = bus.cin;

  // One full-adder cell per bit, rippling the carry upward.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign sum_next[gi]  = bus.a[gi] ^ bus.b[gi] ^ chain[gi];
      assign chain[gi + 1] = (bus.a[gi] & bus.b[gi])
                           | (bus.a[gi] & chain[gi])
                           | (bus.b[gi] & chain[gi]);
    end
  endgenerate

  assign carry_next = chain[WIDTH];

  // Result registers: reset/clear to zero, load only on in_valid so that
  // unqualified (possibly X) operands never reach the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (bus.clr) begin
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (bus.in_valid) begin
      sum_reg       <= sum_next;
      carry_reg     <= carry_next;
      out_valid_reg <= 1'b1;
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.sum       = sum_reg;
  assign bus.carry     = carry_reg;
  assign bus.out_valid = out_valid_reg;

`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  logic overflow_next;
  logic overflow_reg;

  assign overflow_next = chain[WIDTH] ^ chain[WIDTH-1];

  // Overflow register follows the same reset/clear/load rules as sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (bus.clr) begin
      overflow_reg <= 1'b0;
    end else if (bus.in_valid) begin
      overflow_reg <= overflow_next;
    end
  end

  assign bus.overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit: scoreboard bench for full_adder_unit at WIDTH=1 and
// WIDTH=8. Stimulus pushes hand-computed results into per-instance queues;
// negedge monitors pop and compare whenever out_valid is high.
module tb_full_adder_unit;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  full_adder_unit_if #(.WIDTH(1)) bus1 ();
  full_adder_unit_if #(.WIDTH(8)) bus8 ();

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected entries: {overflow, carry, sum}
  logic [2:0] q1 [$];
  logic [9:0] q8 [$];

  // WIDTH=1 truth table, index = {a, b, cin}; entry = {overflow, carry, sum}
  logic [2:0] tt_exp [0:7] = '{3'b000, 3'b101, 3'b001, 3'b010,
                               3'b001, 3'b010, 3'b110, 3'b011};

  // WIDTH=8 directed vectors: a, b, cin, expected sum, carry, overflow
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec8_t;

  vec8_t vecs [0:6] = '{
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
    '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] s, input logic c, input logic o);
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    q8.push_back({o, c, s});
  endtask

  // Monitor for the WIDTH=1 instance
  always @(negedge clk) begin
    if (bus1.out_valid) begin
      if (q1.size() == 0) begin
        check("w1_unexpected_valid", 64'd1, 64'd0);
      end else begin
        logic [2:0] e;
        e = q1.pop_front();
        $display("txn w1: carry=%0b sum=%0b (expected %0b%0b)",
                 bus1.carry, bus1.sum, e[1], e[0]);
        check("w1_carry_sum", {62'd0, bus1.carry, bus1.sum}, {62'd0, e[1:0]});
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
        check("w1_overflow", {63'd0, bus1.overflow}, {63'd0, e[2]});
`endif
      end
    end
  end

  // Monitor for the WIDTH=8 instance
  always @(negedge clk) begin
    if (bus8.out_valid) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_valid", 64'd1, 64'd0);
      end else begin
        logic [9:0] e;
        e = q8.pop_front();
        $display("txn w8: sum=%02h carry=%0b (expected %02h %0b)",
                 bus8.sum, bus8.carry, e[7:0], e[8]);
        check("w8_sum", {56'd0, bus8.sum}, {56'd0, e[7:0]});
        check("w8_carry", {63'd0, bus8.carry}, {63'd0, e[8]});
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
        check("w8_overflow", {63'd0, bus8.overflow}, {63'd0, e[9]});
`endif
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus1.clr = 1'b0; bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus8.clr = 1'b0; bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_w8_sum", {56'd0, bus8.sum}, 64'd0);
    check("rst_w8_carry", {63'd0, bus8.carry}, 64'd0);
    check("rst_w8_valid", {63'd0, bus8.out_valid}, 64'd0);
    check("rst_w1_valid", {63'd0, bus1.out_valid}, 64'd0);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    check("rst_w8_overflow", {63'd0, bus8.overflow}, 64'd0);
`endif
    rst_n = 1'b1;

    // WIDTH=1 truth table, back to back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      bus1.in_valid = 1'b1;
      bus1.a   = v[2];
      bus1.b   = v[1];
      bus1.cin = v[0];
      q1.push_back(tt_exp[i]);
      tick();
    end
    bus1.in_valid = 1'b0;

    // WIDTH=8 directed vectors, back to back
    for (int i = 0; i < 7; i++) begin
      drive8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].carry, vecs[i].ovf);
      tick();
    end
    bus8.in_valid = 1'b0;
    tick();

    // Hold: result stays when in_valid is low, new operands ignored
    drive8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    tick();
    bus8.in_valid = 1'b0;
    bus8.a = 8'hAA;
    bus8.b = 8'hx;
    bus8.cin = 1'bx;
    tick();
    check("hold_sum", {56'd0, bus8.sum}, 64'h46);
    check("hold_carry", {63'd0, bus8.carry}, 64'd0);
    check("hold_valid", {63'd0, bus8.out_valid}, 64'd0);

    // Clear has priority over in_valid
    bus8.clr = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.a = 8'hFF;
    bus8.b = 8'h01;
    bus8.cin = 1'b1;
    tick();
    bus8.clr = 1'b0;
    bus8.in_valid = 1'b0;
    check("clr_sum", {56'd0, bus8.sum}, 64'd0);
    check("clr_carry", {63'd0, bus8.carry}, 64'd0);
    check("clr_valid", {63'd0, bus8.out_valid}, 64'd0);

    // Asynchronous reset between edges
    drive8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    tick();
    bus8.in_valid = 1'b0;
    #5;                     // past the negedge where the monitor consumes 0x46
    rst_n = 1'b0;
    #1;
    check("arst_sum", {56'd0, bus8.sum}, 64'd0);
    check("arst_carry", {63'd0, bus8.carry}, 64'd0);
    check("arst_valid", {63'd0, bus8.out_valid}, 64'd0);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    check("arst_overflow", {63'd0, bus8.overflow}, 64'd0);
`endif
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_valid_1", {63'd0, bus8.out_valid}, 64'd0);
    tick();
    check("post_rst_valid_2", {63'd0, bus8.out_valid}, 64'd0);
    drive8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    tick();
    drive8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    bus8.in_valid = 1'b0;
    tick();
    tick();

    check("w1_queue_drained", 64'(q1.size()), 64'd0);
    check("w8_queue_drained", 64'(q8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
